x_multdiv_unit: RTL

//  Execute-stage iterative multiply/divide engine; consumes the D/X instruction and its already-bypassed operands.

---
 rtl/x_multdiv_unit_pkg.sv | 28 ++
 rtl/x_multdiv_unit_if.sv | 30 +++
 rtl/x_multdiv_unit_core.sv | 88 ++++++++
 rtl/x_multdiv_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/x_multdiv_unit_pkg.sv
// Shared ISA constants, status codes and state/kind types for the execute-stage multiply/divide unit.
// No logic, so no latency.
// No flow control.
package x_multdiv_unit_pkg;

    localparam int INSN_W = 32;

    // Opcode and aluop fields of the R-type format
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Architectural registers with a fixed role
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_RA     = 5'd31;

    // Codes written to rstatus when an operation raises an exception
    localparam logic [31:0] ST_ADD  = 32'd1;
    localparam logic [31:0] ST_ADDI = 32'd2;
    localparam logic [31:0] ST_SUB  = 32'd3;
    localparam logic [31:0] ST_MUL  = 32'd4;
    localparam logic [31:0] ST_DIV  = 32'd5;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic {KIND_MUL, KIND_DIV} md_kind_t;

endpackage

// File: rtl/x_multdiv_unit_if.sv
// Bundle between the D/X/X-M pipeline latches and the multiply/divide unit.
// No logic, so no latency.
// md_stall is the only backpressure: it holds PC, F/D and D/X.
interface x_multdiv_unit_if
    import x_multdiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [INSN_W-1:0] dx_insn;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              flush;
    logic              md_stall;
    logic              md_valid;
    logic [WIDTH-1:0]  md_result;
    logic [4:0]        md_rd;
    logic              md_exc;

    // Pipeline side: supplies the instruction and bypassed operands
    modport master (
        output dx_insn, op_a, op_b, flush,
        input  md_stall, md_valid, md_result, md_rd, md_exc
    );

    // Unit side
    modport slave (
        input  dx_insn, op_a, op_b, flush,
        output md_stall, md_valid, md_result, md_rd, md_exc
    );
endinterface

// File: rtl/x_multdiv_unit_core.sv
// Iterative signed multiply/divide datapath: one bit per step on operand magnitudes, sign fixed on output.
// ITER steps after start (one step if dividing by zero); result is combinational from the final state.
// No backpressure: the caller decides when to start and step.
module x_multdiv_unit_core
    import x_multdiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  md_kind_t         kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             divzero
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    // p: multiply = {partial sum, remaining multiplier}; divide = {remainder, remaining dividend/quotient}
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               dz_q;
    md_kind_t           kind_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_unused_hi;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] p_next;
    logic [2*WIDTH-1:0] prod_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        mul_sum                  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        div_shift                = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        {div_unused_hi, div_rem} = div_shift - {1'b0, m};
        if (kind_q == KIND_MUL)
            p_next = {mul_sum, p[WIDTH-1:1]};
        else if (div_shift >= {1'b0, m})
            p_next = {div_rem, p[WIDTH-2:0], 1'b1};
        else
            p_next = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end

    // Load magnitudes on start, then iterate while stepped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            dz_q   <= 1'b0;
            kind_q <= KIND_MUL;
        end else if (start) begin
            p      <= {{WIDTH{1'b0}}, mag(a)};
            m      <= mag(b);
            cnt    <= '0;
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
            dz_q   <= (kind == KIND_DIV) && (b == '0);
            kind_q <= kind;
        end else if (step) begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
        end
    end

    // A full-width signed product overflows when its top WIDTH+1 bits are not a pure sign extension
    assign prod_s  = neg ? -p : p;
    assign result  = (kind_q == KIND_MUL) ? prod_s[WIDTH-1:0]
                                          : (neg ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
    assign ovf     = (kind_q == KIND_MUL) &&
                     !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign divzero = dz_q;
    assign last    = dz_q || (cnt == CNT_LAST);

endmodule

// File: rtl/x_multdiv_unit.sv
// Execute-stage MUL/DIV: decodes D/X, runs the iterative core, and hands one result to X/M.
// Issue in cycle t, result in cycle t+ITER+1 (t+2 for divide by zero).
// Holds PC, F/D and D/X via md_stall from the issue cycle until the result cycle; flush aborts.
module x_multdiv_unit
    import x_multdiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic clock,
    input  logic reset,
    x_multdiv_unit_if.slave bus
);
    state_t           state;
    logic [4:0]       rd_q;
    logic [4:0]       opcode;
    logic [4:0]       aluop;
    logic             md_op;
    logic             issue;
    md_kind_t         kind;
    logic             core_last;
    logic [WIDTH-1:0] core_result;
    logic             core_ovf;
    logic             core_dz;
    logic             exc;
    logic             unused_insn;

    assign opcode      = bus.dx_insn[31:27];
    assign aluop       = bus.dx_insn[6:2];
    assign unused_insn = &{1'b0, bus.dx_insn[21:7], bus.dx_insn[1:0]};

    assign md_op = (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    assign kind  = (aluop == ALU_DIV) ? KIND_DIV : KIND_MUL;
    // Reset gates the issue path so a held MUL/DIV cannot raise md_stall while in reset
    assign issue = (state == S_IDLE) && md_op && !bus.flush && !reset;

    x_multdiv_unit_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .start   (issue),
        .step    (state == S_BUSY),
        .kind    (kind),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .last    (core_last),
        .result  (core_result),
        .ovf     (core_ovf),
        .divzero (core_dz)
    );

    // Control FSM: DONE always returns to IDLE so the held D/X instruction is never reissued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            rd_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        rd_q  <= bus.dx_insn[26:22];
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.flush)
                        state <= S_IDLE;
                    else if (core_last)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are zero outside the result cycle; exceptions redirect the write to rstatus
    assign exc           = core_ovf || core_dz;
    assign bus.md_stall  = issue || (state == S_BUSY);
    assign bus.md_valid  = (state == S_DONE) && !bus.flush;
    assign bus.md_exc    = bus.md_valid && exc;
    assign bus.md_rd     = !bus.md_valid ? 5'd0 : (exc ? REG_STATUS : rd_q);
    assign bus.md_result = !bus.md_valid ? '0
                         : !exc          ? core_result
                         : core_dz       ? WIDTH'(ST_DIV)
                                         : WIDTH'(ST_MUL);

endmodule
